// File: rtl/puf_reader_pkg.sv
// Package: puf_reader_pkg
// Purpose : Shared types and sizing helpers for the PUF response reader.
//           - state_t     : reader FSM states
//           - cnt_width() : bit width able to hold 0..votes without wrapping
//           - max2()      : larger of two integers, used to size the cycle timer
package puf_reader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRST   = 3'd1,
        RUN    = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int cnt_width(input int votes);
        return $clog2(votes + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_response_reader_sync2.sv
// Module : puf_sync2
// Purpose: Two-flop synchronizer per bit for the asynchronous PUF cell outputs.
// Ports  : clk   - system clock
//          rst_n - asynchronous active-low reset, clears both stages to 0
//          d     - asynchronous input bits
//          q     - synchronized output bits (two cycles of latency)
module puf_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            q      <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/puf_response_reader.sv
// Module : puf_response_reader
// Purpose: Sequences VOTES evaluations of a bank of latch PUF cells, synchronizes
//          their outputs, majority-votes each bit and offers the response on a
//          valid/ready handshake.
// Ports  : clk, rst_n         - clock, asynchronous active-low reset
//          req                - start a read (only looked at while idle)
//          busy               - high in every state except IDLE
//          resp_valid/ready   - response handshake; resp_valid held until accepted
//          resp_data          - majority-voted response, stable while resp_valid
//          puf_start          - START of all PUF cells
//          puf_reset          - reset of all PUF cells (active high)
//          puf_out            - raw asynchronous cell outputs
//          resp_unstable      - only with PUF_STABILITY_EN defined: bit i set when
//                               cell i did not give the same value in every evaluation
// Config : macro PUF_STABILITY_EN adds the resp_unstable port and its logic.
module puf_response_reader
    import puf_reader_pkg::*;
#(
    parameter int N_BITS        = 4,
    parameter int VOTES         = 5,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              busy,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [N_BITS-1:0] resp_data,
    output logic              puf_start,
    output logic              puf_reset,
    input  logic [N_BITS-1:0] puf_out
`ifdef PUF_STABILITY_EN
    ,
    output logic [N_BITS-1:0] resp_unstable
`endif
);

    localparam int CW   = cnt_width(VOTES);
    localparam int TMAX = max2(RST_CYCLES, SETTLE_CYCLES);
    // Timer counts 0..TMAX-1.
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_t                   state_r;
    logic [TW-1:0]            timer_r;
    logic [CW-1:0]            eval_cnt_r;
    logic [N_BITS-1:0][CW-1:0] vote_cnt_r;

    logic [N_BITS-1:0]         sync_out_s;
    logic [N_BITS-1:0][CW-1:0] vote_inc_s;
    logic [N_BITS-1:0]         majority_s;
`ifdef PUF_STABILITY_EN
    logic [N_BITS-1:0]         unstable_s;
`endif

    puf_sync2 #(
        .WIDTH (N_BITS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (puf_out),
        .q     (sync_out_s)
    );

    // Vote counts including the sample being taken this cycle, and the decisions
    // derived from them; only consumed in SAMPLE.
    always_comb begin
        vote_inc_s = {(N_BITS * CW){1'b0}};
        majority_s = {N_BITS{1'b0}};
`ifdef PUF_STABILITY_EN
        unstable_s = {N_BITS{1'b0}};
`endif
        for (int i = 0; i < N_BITS; i++) begin
            vote_inc_s[i] = vote_cnt_r[i] + CW'(sync_out_s[i]);
            majority_s[i] = (vote_inc_s[i] > CW'(VOTES / 2));
`ifdef PUF_STABILITY_EN
            unstable_s[i] = (vote_inc_s[i] != {CW{1'b0}}) && (vote_inc_s[i] != CW'(VOTES));
`endif
        end
    end

    // Reader FSM with timer, counters and all registered outputs. puf_start and
    // puf_reset are updated together on each transition so they are never both high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            timer_r    <= {TW{1'b0}};
            eval_cnt_r <= {CW{1'b0}};
            vote_cnt_r <= {(N_BITS * CW){1'b0}};
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= {N_BITS{1'b0}};
            puf_start  <= 1'b0;
            puf_reset  <= 1'b1;
`ifdef PUF_STABILITY_EN
            resp_unstable <= {N_BITS{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    puf_reset <= 1'b1;
                    puf_start <= 1'b0;
                    if (req) begin
                        state_r    <= PRST;
                        busy       <= 1'b1;
                        timer_r    <= {TW{1'b0}};
                        eval_cnt_r <= {CW{1'b0}};
                        vote_cnt_r <= {(N_BITS * CW){1'b0}};
                    end else begin
                        busy <= 1'b0;
                    end
                end
                PRST: begin
                    if (timer_r == TW'(RST_CYCLES - 1)) begin
                        state_r   <= RUN;
                        timer_r   <= {TW{1'b0}};
                        puf_reset <= 1'b0;
                        puf_start <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                RUN: begin
                    if (timer_r == TW'(SETTLE_CYCLES - 1)) begin
                        state_r <= SAMPLE;
                        timer_r <= {TW{1'b0}};
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                SAMPLE: begin
                    vote_cnt_r <= vote_inc_s;
                    eval_cnt_r <= eval_cnt_r + CW'(1);
                    puf_reset  <= 1'b1;
                    puf_start  <= 1'b0;
                    if (eval_cnt_r == CW'(VOTES - 1)) begin
                        state_r    <= DONE;
                        resp_valid <= 1'b1;
                        resp_data  <= majority_s;
`ifdef PUF_STABILITY_EN
                        resp_unstable <= unstable_s;
`endif
                    end else begin
                        state_r <= PRST;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_r    <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        resp_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                    puf_start  <= 1'b0;
                    puf_reset  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_reader.sv
// Testbench for puf_response_reader: behavioural PUF bank with per-evaluation
// scripted values, scoreboard queue checked by a monitor on each new response,
// plus a second instance with VOTES=1, RST_CYCLES=1, SETTLE_CYCLES=3.
module tb_puf_response_reader;

    typedef struct {
        logic [3:0] data;
        logic [3:0] unstable;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req, resp_ready;
    logic       busy, resp_valid, puf_start, puf_reset;
    logic [3:0] resp_data, puf_out;
    logic       req2, resp_ready2;
    logic       busy2, resp_valid2, puf_start2, puf_reset2;
    logic [3:0] resp_data2, puf_out2;
`ifdef PUF_STABILITY_EN
    logic [3:0] resp_unstable, resp_unstable2;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    int   resp_count = 0;
    int   cyc = 0;
    int   last_accept = 0;
    exp_t exp_q[$];

    logic [3:0] script [5];
    logic [3:0] cur_val = 4'b0000;
    int         eval_idx = 0;
    logic       start_d = 1'b0;
    int         start_rises = 0;
    int         start_hi = 0;

    always #5 clk = ~clk;

    puf_response_reader #(.N_BITS(4), .VOTES(5), .RST_CYCLES(4), .SETTLE_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .busy(busy), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .puf_start(puf_start),
        .puf_reset(puf_reset), .puf_out(puf_out)
`ifdef PUF_STABILITY_EN
        , .resp_unstable(resp_unstable)
`endif
    );

    puf_response_reader #(.N_BITS(4), .VOTES(1), .RST_CYCLES(1), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .busy(busy2), .resp_valid(resp_valid2),
        .resp_ready(resp_ready2), .resp_data(resp_data2), .puf_start(puf_start2),
        .puf_reset(puf_reset2), .puf_out(puf_out2)
`ifdef PUF_STABILITY_EN
        , .resp_unstable(resp_unstable2)
`endif
    );

    // PUF bank model: cells show their value only while START is high.
    assign puf_out  = puf_start  ? cur_val : 4'b0000;
    assign puf_out2 = puf_start2 ? 4'b0110 : 4'b0000;

    // Picks the scripted value for each evaluation and counts START activity.
    always @(negedge clk) begin
        if (!busy) begin
            eval_idx = 0;
        end else if (puf_start && !start_d) begin
            cur_val  = script[eval_idx % 5];
            eval_idx = eval_idx + 1;
        end
        if (puf_start && !start_d) start_rises = start_rises + 1;
        if (puf_start) start_hi = start_hi + 1;
        start_d = puf_start;
    end

    // Cycle counter and timestamp of each accepted request.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req && !busy) last_accept <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [3:0] d, input logic [3:0] u);
        exp_t e;
        e.data = d;
        e.unstable = u;
        exp_q.push_back(e);
    endtask

    task automatic monitor_loop();
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            check("start_reset_excl",  {31'd0, puf_start & puf_reset}, 32'd0);
            check("start_reset_excl2", {31'd0, puf_start2 & puf_reset2}, 32'd0);
            if (resp_valid && !prev_valid) begin
                resp_count = resp_count + 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", {28'd0, resp_data}, {28'd0, e.data});
`ifdef PUF_STABILITY_EN
                    check("resp_unstable", {28'd0, resp_unstable}, {28'd0, e.unstable});
`endif
                    check("latency", 32'(cyc - last_accept), 32'd65);
                end
            end
            prev_valid = resp_valid;
        end
    endtask

    task automatic pulse_req();
        @(negedge clk) req = 1'b1;
        @(negedge clk) req = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) check(name, 32'd0, 32'd1);
    endtask

    task automatic set_script(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d, input logic [3:0] e);
        script[0] = a; script[1] = b; script[2] = c; script[3] = d; script[4] = e;
    endtask

    initial begin
        int rises0, hi0, n;
        rst_n = 1'b0; req = 1'b0; resp_ready = 1'b0; req2 = 1'b0; resp_ready2 = 1'b0;
        set_script(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        fork
            monitor_loop();
        join_none
        repeat (3) @(negedge clk);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        check("rst_valid",      {31'd0, resp_valid}, 32'd0);
        check("rst_data",       {28'd0, resp_data}, 32'd0);
        check("rst_puf_start",  {31'd0, puf_start}, 32'd0);
        check("rst_puf_reset",  {31'd0, puf_reset}, 32'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_resp", {31'd0, resp_valid}, 32'd0);

        // Stable cells 1010, immediate acceptance.
        set_script(4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010);
        resp_ready = 1'b1;
        rises0 = start_rises;
        hi0 = start_hi;
        expect_resp(4'b1010, 4'b0000);
        pulse_req();
        wait_valid("stable_timeout");
        @(negedge clk);
        check("stable_busy_after", {31'd0, busy}, 32'd0);
        check("stable_valid_after", {31'd0, resp_valid}, 32'd0);
        check("stable_data_kept", {28'd0, resp_data}, 32'h0000000a);
        check("start_pulses", 32'(start_rises - rises0), 32'd5);
        // Each evaluation: 8 RUN cycles plus the SAMPLE cycle with START still high.
        check("start_hi_cycles", 32'(start_hi - hi0), 32'd45);

        // Majority: bit0 1,1,0,0,1 ; bit1 0,1,0,1,0 ; bit2 always 1 ; bit3 always 0.
        set_script(4'b0101, 4'b0111, 4'b0100, 4'b0110, 4'b0101);
        expect_resp(4'b0101, 4'b0011);
        pulse_req();
        wait_valid("majority_timeout");
        @(negedge clk);

        // Backpressure for 20 cycles.
        set_script(4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010);
        resp_ready = 1'b0;
        expect_resp(4'b1010, 4'b0000);
        pulse_req();
        wait_valid("bp_timeout");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_valid_held", {31'd0, resp_valid}, 32'd1);
            check("bp_data_stable", {28'd0, resp_data}, 32'h0000000a);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_busy_after", {31'd0, busy}, 32'd0);
        check("bp_valid_after", {31'd0, resp_valid}, 32'd0);

        // Requests while busy are ignored.
        set_script(4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100);
        expect_resp(4'b1100, 4'b0000);
        pulse_req();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            req = busy && (i % 3 == 0);
        end
        req = 1'b0;
        wait_valid("busyreq_timeout");
        repeat (80) @(negedge clk);
        check("busyreq_single", 32'(resp_count), 32'd4);
        check("busyreq_idle", {31'd0, busy}, 32'd0);

        // req held high: back-to-back reads.
        set_script(4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110);
        expect_resp(4'b0110, 4'b0000);
        expect_resp(4'b0110, 4'b0000);
        @(negedge clk) req = 1'b1;
        wait_valid("b2b_first_timeout");
        @(negedge clk);
        check("b2b_idle_gap", {31'd0, busy}, 32'd0);
        check("b2b_valid_gap", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        check("b2b_restart", {31'd0, busy}, 32'd1);
        req = 1'b0;
        wait_valid("b2b_second_timeout");
        @(negedge clk);

        // Reset in the middle of RUN.
        set_script(4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
        pulse_req();
        n = 0;
        while (!puf_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_run", {31'd0, puf_start}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_puf_reset", {31'd0, puf_reset}, 32'd1);
        check("abort_puf_start", {31'd0, puf_start}, 32'd0);
        check("abort_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        check("abort_no_busy", {31'd0, busy}, 32'd0);

        // Minimal build: one vote, latency 5.
        resp_ready2 = 1'b1;
        @(negedge clk) req2 = 1'b1;
        @(negedge clk) req2 = 1'b0;
        n = 0;
        while (!resp_valid2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("min_latency", 32'(n), 32'd5);
        check("min_data", {28'd0, resp_data2}, 32'h00000006);
`ifdef PUF_STABILITY_EN
        check("min_unstable", {28'd0, resp_unstable2}, 32'd0);
`endif
        @(negedge clk);
        check("min_valid_after", {31'd0, resp_valid2}, 32'd0);
        check("min_busy_after", {31'd0, busy2}, 32'd0);

        check("total_responses", 32'(resp_count), 32'd6);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
